// File: rtl/aom_flag_trim_mc.sv
// Multi-channel AOM/laser-power flag trim: clamped per-channel delay, timestamp FIFO of
// pending hits, hold-extended delayed flag and edge-slot flag per channel.
module aom_flag_trim_mc #(
  parameter int CH_NUM     = 2,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 laser_start_i,
  input  logic                 filter_unit_vld_i,
  input  logic                 filter_acc_result_i,
  input  logic [DW-1:0]        light_spot_para_i,
  input  logic [CH_NUM*DW-1:0] ch_delay_i,
  input  logic [CH_NUM-1:0]    ch_chain_i,
  input  logic [CH_NUM*DW-1:0] ch_hold_i,
  input  logic [CH_NUM*DW-1:0] ch_slot_i,
  output logic [CH_NUM*DW-1:0] ch_delay_abs_o,
  output logic [CH_NUM-1:0]    ch_flag_o,
  output logic [CH_NUM-1:0]    ch_edge_flag_o,
  output logic [CH_NUM-1:0]    ch_ovf_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Saturate a widened signed delay sum into [1, 2^(DW-1)-1].
  function automatic logic [DW-1:0] sat_delay(input logic signed [DW+1:0] sum);
    logic signed [DW+1:0] lo;
    logic signed [DW+1:0] hi;
    lo = $signed({{(DW+1){1'b0}}, 1'b1});
    hi = $signed({3'b000, {(DW-1){1'b1}}});
    if (sum < lo) return lo[DW-1:0];
    if (sum > hi) return hi[DW-1:0];
    return sum[DW-1:0];
  endfunction

  logic [DW-1:0] ts_q;
  logic          trig;

  assign trig = laser_start_i & filter_unit_vld_i & filter_acc_result_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)           ts_q <= '0;
    else if (!laser_start_i) ts_q <= '0;
    else                    ts_q <= ts_q + 1'b1;
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    logic        [DW-1:0] base;
    logic        [DW-1:0] offs;
    logic        [DW-1:0] hold;
    logic        [DW-1:0] slot;
    logic signed [DW+1:0] sum;
    logic        [DW-1:0] eff_p0;
    logic        [DW-1:0] due;
    logic        [DW-1:0] head;
    logic        [DW-1:0] age;
    logic        [DW-1:0] mem [FIFO_DEPTH];
    logic        [AW-1:0] wp_q;
    logic        [AW-1:0] rp_q;
    logic        [AW:0]   cnt_q;
    logic        [DW-1:0] hcnt_q;
    logic        [DW-1:0] ecnt_q;
    logic                 flag_prev_q;
    logic                 ovf_q;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 flag;

    assign offs = ch_delay_i[g*DW +: DW];
    assign hold = ch_hold_i[g*DW +: DW];
    assign slot = ch_slot_i[g*DW +: DW];
    // A chained channel builds on the previous channel's registered delay.
    assign base = (g != 0 && ch_chain_i[g]) ? ch_delay_abs_o[(g == 0 ? 0 : g-1)*DW +: DW]
                                            : light_spot_para_i;
    assign sum  = $signed({2'b00, base}) + $signed({{2{offs[DW-1]}}, offs});

    // Stage p0: effective delay register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) eff_p0 <= '0;
      else          eff_p0 <= sat_delay(sum);
    end

    assign ch_delay_abs_o[g*DW +: DW] = eff_p0;

    assign head = mem[rp_q];
    assign age  = ts_q - head;
    assign full = cnt_q[AW];
    assign pop  = (cnt_q != '0) && !age[DW-1];
    assign push = trig && (!full || pop);
    assign due  = ts_q + eff_p0;
    assign flag = (hcnt_q != '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        wp_q        <= '0;
        rp_q        <= '0;
        cnt_q       <= '0;
        hcnt_q      <= '0;
        ecnt_q      <= '0;
        flag_prev_q <= 1'b0;
        ovf_q       <= 1'b0;
      end else if (!laser_start_i) begin
        wp_q        <= '0;
        rp_q        <= '0;
        cnt_q       <= '0;
        hcnt_q      <= '0;
        ecnt_q      <= '0;
        flag_prev_q <= 1'b0;
        ovf_q       <= 1'b0;
      end else begin
        if (push) begin
          mem[wp_q] <= due;
          wp_q      <= wp_q + 1'b1;
        end
        if (pop) rp_q <= rp_q + 1'b1;
        if (push && !pop)      cnt_q <= cnt_q + 1'b1;
        else if (!push && pop) cnt_q <= cnt_q - 1'b1;
        if (trig && full && !pop) ovf_q <= 1'b1;
        // A fire during an active hold reloads it, so the flag never gaps.
        if (pop && hold != '0) hcnt_q <= hold;
        else if (flag)         hcnt_q <= hcnt_q - 1'b1;
        flag_prev_q <= flag;
        if ((flag != flag_prev_q) && slot != '0) ecnt_q <= slot;
        else if (ecnt_q != '0)                   ecnt_q <= ecnt_q - 1'b1;
      end
    end

    assign ch_flag_o[g]      = flag;
    assign ch_edge_flag_o[g] = (ecnt_q != '0) && (slot != '0);
    assign ch_ovf_o[g]       = ovf_q;
  end

endmodule

// File: tb/tb_aom_flag_trim_mc.sv
// Directed bench for aom_flag_trim_mc: delay clamp/chain table plus hand-built
// pulse, queue, overflow, clear and reset sequences.
module tb_aom_flag_trim_mc;
  localparam int CH_NUM     = 2;
  localparam int DW         = 16;
  localparam int FIFO_DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 laser_start = 1'b0;
  logic                 fvld = 1'b0;
  logic                 facc = 1'b0;
  logic [DW-1:0]        spot = '0;
  logic [CH_NUM*DW-1:0] ch_delay = '0;
  logic [CH_NUM-1:0]    chain = '0;
  logic [CH_NUM*DW-1:0] ch_hold = '0;
  logic [CH_NUM*DW-1:0] ch_slot = '0;
  logic [CH_NUM*DW-1:0] delay_abs;
  logic [CH_NUM-1:0]    flag;
  logic [CH_NUM-1:0]    eflag;
  logic [CH_NUM-1:0]    ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aom_flag_trim_mc #(.CH_NUM(CH_NUM), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .laser_start_i       (laser_start),
    .filter_unit_vld_i   (fvld),
    .filter_acc_result_i (facc),
    .light_spot_para_i   (spot),
    .ch_delay_i          (ch_delay),
    .ch_chain_i          (chain),
    .ch_hold_i           (ch_hold),
    .ch_slot_i           (ch_slot),
    .ch_delay_abs_o      (delay_abs),
    .ch_flag_o           (flag),
    .ch_edge_flag_o      (eflag),
    .ch_ovf_o            (ovf)
  );

  typedef struct {
    logic [15:0] spot;
    logic [15:0] off0;
    logic [15:0] off1;
    logic        chain1;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } dly_vec_t;

  dly_vec_t vt[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rng(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic set_dly(input logic [15:0] s, input logic [15:0] o0, input logic [15:0] o1,
                         input logic c1);
    spot     = s;
    ch_delay = {o1, o0};
    chain    = {c1, 1'b0};
  endtask

  // Cycle 0 of the capture is the first cycle after a one-cycle run clear.
  task automatic run_seq(input logic [127:0] tmask, input logic [127:0] lmask,
                         output logic [127:0] f0, output logic [127:0] e0,
                         output logic [127:0] f1, output logic [127:0] e1,
                         output logic [127:0] ov0);
    laser_start = 1'b0;
    fvld = 1'b0;
    facc = 1'b0;
    step();
    f0 = '0; e0 = '0; f1 = '0; e1 = '0; ov0 = '0;
    for (int i = 0; i < 128; i++) begin
      f0[i]  = flag[0];
      e0[i]  = eflag[0];
      f1[i]  = flag[1];
      e1[i]  = eflag[1];
      ov0[i] = ovf[0];
      laser_start = lmask[i];
      fvld = 1'b1;
      facc = tmask[i];
      step();
    end
    fvld = 1'b0;
    facc = 1'b0;
  endtask

  logic [127:0] ones;
  logic [127:0] f0, e0, f1, e1, ov0;
  logic [127:0] obs;

  initial begin
    ones = '1;
    vt[0] = '{16'd10,    16'hFFEC, 16'd5,    1'b0, 16'd1,    16'd15};
    vt[1] = '{16'h0020,  16'h7FF0, 16'hFFFD, 1'b1, 16'h7FFF, 16'h7FFC};
    vt[2] = '{16'd10,    16'd5,    16'hFFF6, 1'b0, 16'd15,   16'd1};
    vt[3] = '{16'd100,   16'd20,   16'hFFE2, 1'b1, 16'd120,  16'd90};
    vt[4] = '{16'hFFFF,  16'h0000, 16'h8000, 1'b0, 16'h7FFF, 16'h7FFF};
    vt[5] = '{16'd0,     16'd1,    16'h7FFE, 1'b1, 16'd1,    16'h7FFF};
    vt[6] = '{16'd0,     16'd0,    16'hFFFF, 1'b1, 16'd1,    16'd1};

    rst_n = 1'b0;
    step();
    step();
    check("rst_delay", delay_abs, '0);
    check("rst_flags", {flag, eflag, ovf}, '0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      set_dly(vt[i].spot, vt[i].off0, vt[i].off1, vt[i].chain1);
      step();
      step();
      check($sformatf("delay0_v%0d", i), delay_abs[15:0], vt[i].exp0);
      check($sformatf("delay1_v%0d", i), delay_abs[31:16], vt[i].exp1);
    end

    // Chain latency: ch1 still reflects old ch0 (1) after one clock.
    set_dly(16'd100, 16'd20, 16'hFFE2, 1'b1);
    step();
    check("chain_lat_ch0_1clk", delay_abs[15:0], 16'd120);
    check("chain_lat_ch1_1clk", delay_abs[31:16], 16'd1);
    step();
    check("chain_lat_ch1_2clk", delay_abs[31:16], 16'd90);

    // Single hit, eff=15 hold=4 slot=3; ch1 hold=0 must stay quiet.
    set_dly(16'd10, 16'd5, 16'd5, 1'b0);
    ch_hold = {16'd0, 16'd4};
    ch_slot = {16'd2, 16'd3};
    step();
    step();
    run_seq(128'h1, ones, f0, e0, f1, e1, ov0);
    check("single_flag0", f0, rng(16, 19));
    check("single_edge0", e0, rng(17, 19) | rng(21, 23));
    check("hold0_flag1", f1, '0);
    check("hold0_edge1", e1, '0);

    // Queued hits, eff=50, trigs at 0/5/10.
    set_dly(16'd50, 16'd0, 16'd0, 1'b0);
    ch_hold = {16'd0, 16'd2};
    ch_slot = {16'd0, 16'd0};
    step();
    step();
    run_seq(rng(0, 0) | rng(5, 5) | rng(10, 10), ones, f0, e0, f1, e1, ov0);
    check("queued_flag0", f0, rng(51, 52) | rng(56, 57) | rng(61, 62));
    check("slot0_edge0", e0, '0);

    ch_hold = {16'd0, 16'd10};
    ch_slot = {16'd0, 16'd1};
    run_seq(rng(0, 0) | rng(5, 5) | rng(10, 10), ones, f0, e0, f1, e1, ov0);
    check("merged_flag0", f0, rng(51, 70));
    check("merged_edge0", e0, rng(52, 52) | rng(72, 72));

    // Overflow: 10 back-to-back hits into an 8-deep queue.
    set_dly(16'd100, 16'd0, 16'd0, 1'b0);
    ch_hold = {16'd0, 16'd1};
    ch_slot = {16'd0, 16'd0};
    step();
    step();
    run_seq(rng(0, 9), ones, f0, e0, f1, e1, ov0);
    check("ovf_flag0", f0, rng(101, 108));
    check("ovf_sticky0", ov0, rng(9, 127));
    check("ovf_sticky1", ovf[1], 1'b1);

    // Run-enable drop at cycle 20 must discard the queued hits and the overflow.
    run_seq(rng(0, 2), ones & ~rng(20, 20), f0, e0, f1, e1, ov0);
    check("clear_flag0", f0, '0);
    check("clear_ovf0", ov0, '0);

    // Async reset in the middle of a pulse with a second hit still queued.
    set_dly(16'd10, 16'd5, 16'd5, 1'b0);
    ch_hold = {16'd0, 16'd10};
    ch_slot = {16'd0, 16'd8};
    step();
    step();
    laser_start = 1'b0;
    step();
    laser_start = 1'b1;
    fvld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      facc = (i == 0 || i == 10);
      step();
    end
    facc = 1'b0;
    check("pre_rst_active", {eflag[0], flag[0]}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", {delay_abs, flag, eflag, ovf}, '0);
    step();
    step();
    rst_n = 1'b1;
    obs = '0;
    for (int i = 0; i < 60; i++) begin
      obs[i] = flag[0] | eflag[0];
      step();
    end
    check("post_rst_stale", obs, '0);
    fvld = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
